// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lock_pkg
// Description : Shared definitions for the digital-lock sequencer: FSM state
//               encoding, blink pattern codes and keypad code limits.
// Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

  // Sequencer states; 3-bit encoding covers all seven states
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ENTRY      = 3'd1,
    CHECK      = 3'd2,
    BLINK_ACK  = 3'd3,
    BLINK_WAIT = 3'd4,
    UNLOCKED   = 3'd5,
    LOCKOUT    = 3'd6
  } lock_state_t;

  // Blink pattern select values
  localparam logic BLINK_OK   = 1'b0;
  localparam logic BLINK_FAIL = 1'b1;

  // Keypad code range; anything outside KEY_MIN..KEY_MAX is not a digit
  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam logic [3:0] KEY_MIN  = 4'd1;
  localparam logic [3:0] KEY_MAX  = 4'd9;

  // True when the key code is an enterable digit
  function automatic logic is_digit(input logic [3:0] key);
    return (key != KEY_NONE) && (key >= KEY_MIN) && (key <= KEY_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/press_detect.sv
`default_nettype none
// ============================================================================
// Module      : press_detect
// Description : Synchronizes the asynchronous key-held level, detects its
//               rising edge and qualifies the sampled key code as a digit.
//               press_valid is high for exactly one cycle per valid press.
// Revision    : 1.0 - initial release
// ============================================================================
module press_detect
  import lock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bstate,
  input  logic [3:0] button,
  output logic       press_valid,
  output logic [3:0] press_digit
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // Two-flop synchronizer followed by one delay stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= bstate;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  // Key code is sampled on the edge cycle; button is stable while held
  always_comb begin
    press_digit = button;
    press_valid = sync_2 && !sync_prev && is_digit(button);
  end

endmodule
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lock_sequencer
// Description : Central controller of the digital lock. Assembles keypad
//               digits into an entry, compares it with the stored code,
//               drives the blinker handshake and the lock/lockout state.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int          CODE_LEN       = 4,
  parameter logic [27:0] CODE           = 28'h0001234,
  parameter int          MAX_FAILS      = 3,
  parameter int          TIMEOUT_CYCLES = 60_000_000,
  parameter int          LOCKOUT_CYCLES = 120_000_000
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic [3:0] button,
  input  logic       bstate,
  output logic       start_blinking,
  output logic       blink_type,
  input  logic       done_blinking,
  output logic       unlocked,
  output logic       locked_out,
  output logic [2:0] digit_count,
  output logic [2:0] fail_count
);

  localparam int EW = 4 * CODE_LEN;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [EW-1:0] CODE_VAL     = CODE[EW-1:0];
  localparam logic [2:0]    LAST_DIGIT   = 3'(CODE_LEN - 1);
  localparam logic [2:0]    FAIL_LIMIT   = 3'(MAX_FAILS);
  localparam logic [2:0]    FAIL_SAT     = 3'd7;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCKOUT_LAST = LW'(LOCKOUT_CYCLES - 1);

  lock_state_t   state;
  lock_state_t   next_state;
  logic [EW-1:0] entry;
  logic [TW-1:0] idle_cnt;
  logic [LW-1:0] lock_cnt;
  logic          fail_result;
  logic          press_valid;
  logic [3:0]    press_digit;
  logic          match;
  logic          timeout_hit;
  logic          lockout_done;

  press_detect u_press_detect (
    .clk         (hwclk),
    .rst         (rst),
    .bstate      (bstate),
    .button      (button),
    .press_valid (press_valid),
    .press_digit (press_digit)
  );

  assign match        = (entry == CODE_VAL);
  assign timeout_hit  = (idle_cnt == TIMEOUT_LAST);
  assign lockout_done = (lock_cnt == LOCKOUT_LAST);

  // State register
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a press takes priority over a same-cycle timeout
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (press_valid) begin
          next_state = (CODE_LEN == 1) ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        if (press_valid) begin
          if (digit_count == LAST_DIGIT) begin
            next_state = CHECK;
          end
        end else if (timeout_hit) begin
          next_state = IDLE;
        end
      end
      CHECK: next_state = BLINK_ACK;
      BLINK_ACK: begin
        if (!done_blinking) begin
          next_state = BLINK_WAIT;
        end
      end
      BLINK_WAIT: begin
        if (done_blinking) begin
          if (fail_result == BLINK_OK) begin
            next_state = UNLOCKED;
          end else if (fail_count == FAIL_LIMIT) begin
            next_state = LOCKOUT;
          end else begin
            next_state = IDLE;
          end
        end
      end
      UNLOCKED: begin
        if (press_valid) begin
          next_state = IDLE;
        end
      end
      LOCKOUT: begin
        if (lockout_done) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Entry register, digit/fail counters, idle and lockout timers
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      entry       <= '0;
      digit_count <= 3'd0;
      fail_count  <= 3'd0;
      idle_cnt    <= '0;
      lock_cnt    <= '0;
      fail_result <= BLINK_OK;
    end else begin
      lock_cnt <= '0;
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (press_valid) begin
            entry       <= EW'(press_digit);
            digit_count <= 3'd1;
          end
        end
        ENTRY: begin
          if (press_valid) begin
            entry       <= EW'({entry, press_digit});
            digit_count <= digit_count + 3'd1;
            idle_cnt    <= '0;
          end else if (timeout_hit) begin
            entry       <= '0;
            digit_count <= 3'd0;
            idle_cnt    <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        CHECK: begin
          entry       <= '0;
          digit_count <= 3'd0;
          fail_result <= match ? BLINK_OK : BLINK_FAIL;
          if (match) begin
            fail_count <= 3'd0;
          end else if (fail_count != FAIL_SAT) begin
            fail_count <= fail_count + 3'd1;
          end
        end
        LOCKOUT: begin
          if (lockout_done) begin
            fail_count <= 3'd0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only; blink_type holds the
  // last verdict so it stays stable through the blinker handshake
  always_comb begin
    start_blinking = (state == CHECK);
    blink_type     = (state == CHECK) ? (match ? BLINK_OK : BLINK_FAIL) : fail_result;
    unlocked       = (state == UNLOCKED);
    locked_out     = (state == LOCKOUT);
  end

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_sequencer
// Description : Directed self-checking bench for lock_sequencer with a small
//               blinker model answering the start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_sequencer;

  logic       hwclk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] button = 4'd0;
  logic       bstate = 1'b0;
  logic       start_blinking;
  logic       blink_type;
  logic       done_blinking;
  logic       unlocked;
  logic       locked_out;
  logic [2:0] digit_count;
  logic [2:0] fail_count;

  int checks = 0;
  int errors = 0;

  // Observations of the blink request, gathered on each rising edge
  int         pulses = 0;
  logic       last_type = 1'b0;
  logic [2:0] cap_dc = 3'd0;
  logic [3:0] blk_cnt;

  lock_sequencer #(
    .CODE_LEN       (4),
    .CODE           (28'h0001234),
    .MAX_FAILS      (3),
    .TIMEOUT_CYCLES (100),
    .LOCKOUT_CYCLES (200)
  ) dut (
    .hwclk          (hwclk),
    .rst            (rst),
    .button         (button),
    .bstate         (bstate),
    .start_blinking (start_blinking),
    .blink_type     (blink_type),
    .done_blinking  (done_blinking),
    .unlocked       (unlocked),
    .locked_out     (locked_out),
    .digit_count    (digit_count),
    .fail_count     (fail_count)
  );

  always #5 hwclk = ~hwclk;

  // Blinker model: done falls 2 cycles after the request, rises 10 later
  always @(posedge hwclk or posedge rst) begin
    if (rst) begin
      blk_cnt       <= 4'd0;
      done_blinking <= 1'b1;
    end else begin
      if (start_blinking) blk_cnt <= 4'd1;
      else if (blk_cnt != 4'd0 && blk_cnt != 4'd12) blk_cnt <= blk_cnt + 4'd1;
      done_blinking <= !(blk_cnt >= 4'd2 && blk_cnt <= 4'd11);
    end
  end

  // Record every cycle the request is high, with its pattern and digit count
  always @(posedge hwclk) begin
    if (start_blinking) begin
      pulses    <= pulses + 1;
      last_type <= blink_type;
      cap_dc    <= digit_count;
    end
  end

  task automatic press(input logic [3:0] d);
    @(negedge hwclk);
    button = d;
    bstate = 1'b1;
    repeat (4) @(negedge hwclk);
    bstate = 1'b0;
    repeat (4) @(negedge hwclk);
    button = 4'd0;
  endtask

  task automatic enter_code(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge hwclk);
    rst = 1'b0;
    @(negedge hwclk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge hwclk);
    checks++; if ({start_blinking, blink_type, unlocked, locked_out} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {start_blinking, blink_type, unlocked, locked_out});
    end
    checks++; if (digit_count !== 3'd0 || fail_count !== 3'd0) begin
      errors++; $display("FAIL reset_counts got dc=%0d fc=%0d want 0/0", digit_count, fail_count);
    end
    rst = 1'b0;
    @(negedge hwclk);
  endtask

  task automatic test_unlock();
    int p0;
    logic [2:0] exp_dc;
    p0 = pulses;
    for (int i = 1; i <= 3; i++) begin
      press(4'(i));
      exp_dc = 3'(i);
      checks++; if (digit_count !== exp_dc) begin
        errors++; $display("FAIL unlock_dc%0d got %0d want %0d", i, digit_count, exp_dc);
      end
    end
    press(4'd4);
    repeat (25) @(negedge hwclk);
    checks++; if (pulses - p0 !== 1 || last_type !== 1'b0 || cap_dc !== 3'd4) begin
      errors++; $display("FAIL unlock_pulse got n=%0d type=%b dc=%0d want 1/0/4", pulses - p0, last_type, cap_dc);
    end
    checks++; if (unlocked !== 1'b1 || fail_count !== 3'd0) begin
      errors++; $display("FAIL unlock_state got unl=%b fc=%0d want 1/0", unlocked, fail_count);
    end
    press(4'd5);
    checks++; if (unlocked !== 1'b0 || digit_count !== 3'd0) begin
      errors++; $display("FAIL relock got unl=%b dc=%0d want 0/0", unlocked, digit_count);
    end
  endtask

  task automatic test_wrong_code();
    int p0;
    p0 = pulses;
    enter_code(16'h1235);
    repeat (25) @(negedge hwclk);
    checks++; if (pulses - p0 !== 1 || last_type !== 1'b1) begin
      errors++; $display("FAIL wrong_pulse got n=%0d type=%b want 1/1", pulses - p0, last_type);
    end
    checks++; if (fail_count !== 3'd1 || unlocked !== 1'b0 || locked_out !== 1'b0 || digit_count !== 3'd0) begin
      errors++; $display("FAIL wrong_state got fc=%0d unl=%b lo=%b dc=%0d want 1/0/0/0", fail_count, unlocked, locked_out, digit_count);
    end
  endtask

  task automatic test_lockout();
    int n;
    int p0;
    logic bad;
    do_reset();
    enter_code(16'h9999);
    repeat (25) @(negedge hwclk);
    enter_code(16'h4321);
    repeat (25) @(negedge hwclk);
    checks++; if (fail_count !== 3'd2 || locked_out !== 1'b0) begin
      errors++; $display("FAIL lock_pre got fc=%0d lo=%b want 2/0", fail_count, locked_out);
    end
    enter_code(16'h1111);
    n = 0;
    while (!locked_out && n < 60) begin
      @(negedge hwclk);
      n++;
    end
    checks++; if (locked_out !== 1'b1 || fail_count !== 3'd3) begin
      errors++; $display("FAIL lock_entry got lo=%b fc=%0d want 1/3", locked_out, fail_count);
    end
    p0 = pulses;
    bad = 1'b0;
    n = 0;
    while (locked_out && n < 300) begin
      @(negedge hwclk);
      n++;
      if (n == 10 || n == 40) begin button = 4'd1; bstate = 1'b1; end
      if (n == 20 || n == 50) begin bstate = 1'b0; button = 4'd0; end
      if (digit_count != 3'd0 || unlocked) bad = 1'b1;
    end
    bstate = 1'b0;
    checks++; if (n !== 200) begin
      errors++; $display("FAIL lock_duration got %0d want 200", n);
    end
    checks++; if (bad !== 1'b0 || pulses != p0) begin
      errors++; $display("FAIL lock_ignore got bad=%b pulses=%0d want 0/0", bad, pulses - p0);
    end
    checks++; if (fail_count !== 3'd0 || locked_out !== 1'b0) begin
      errors++; $display("FAIL lock_exit got fc=%0d lo=%b want 0/0", fail_count, locked_out);
    end
  endtask

  task automatic test_timeout();
    press(4'd1);
    press(4'd2);
    repeat (50) @(negedge hwclk);
    checks++; if (digit_count !== 3'd2) begin
      errors++; $display("FAIL timeout_early got dc=%0d want 2", digit_count);
    end
    repeat (100) @(negedge hwclk);
    checks++; if (digit_count !== 3'd0 || fail_count !== 3'd0) begin
      errors++; $display("FAIL timeout_clear got dc=%0d fc=%0d want 0/0", digit_count, fail_count);
    end
    enter_code(16'h1234);
    repeat (25) @(negedge hwclk);
    checks++; if (unlocked !== 1'b1) begin
      errors++; $display("FAIL timeout_unlock got %b want 1", unlocked);
    end
  endtask

  task automatic test_invalid_keys();
    press(4'd5);
    press(4'd0);
    press(4'd11);
    checks++; if (digit_count !== 3'd0 || unlocked !== 1'b0) begin
      errors++; $display("FAIL invalid_key got dc=%0d unl=%b want 0/0", digit_count, unlocked);
    end
    @(negedge hwclk);
    button = 4'd7;
    bstate = 1'b1;
    repeat (50) @(negedge hwclk);
    checks++; if (digit_count !== 3'd1) begin
      errors++; $display("FAIL held_key got dc=%0d want 1", digit_count);
    end
    bstate = 1'b0;
    repeat (4) @(negedge hwclk);
    press(4'd8);
    checks++; if (digit_count !== 3'd2) begin
      errors++; $display("FAIL second_edge got dc=%0d want 2", digit_count);
    end
    repeat (150) @(negedge hwclk);
  endtask

  task automatic test_async_reset();
    int p0;
    enter_code(16'h1235);
    repeat (2) @(negedge hwclk);
    checks++; if (blink_type !== 1'b1 || done_blinking !== 1'b0) begin
      errors++; $display("FAIL mid_blink got type=%b done=%b want 1/0", blink_type, done_blinking);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({start_blinking, blink_type, unlocked, locked_out, digit_count, fail_count} !== 10'd0) begin
      errors++; $display("FAIL rst_blink got %b want 0", {start_blinking, blink_type, unlocked, locked_out, digit_count, fail_count});
    end
    @(negedge hwclk);
    rst = 1'b0;
    repeat (30) @(negedge hwclk);
    checks++; if (unlocked !== 1'b0 || fail_count !== 3'd0) begin
      errors++; $display("FAIL rst_blink_after got unl=%b fc=%0d want 0/0", unlocked, fail_count);
    end
    press(4'd1);
    press(4'd2);
    #2 rst = 1'b1;
    #1;
    checks++; if (digit_count !== 3'd0) begin
      errors++; $display("FAIL rst_entry got dc=%0d want 0", digit_count);
    end
    @(negedge hwclk);
    rst = 1'b0;
    @(negedge hwclk);
    p0 = pulses;
    enter_code(16'h1234);
    repeat (25) @(negedge hwclk);
    checks++; if (unlocked !== 1'b1 || pulses - p0 !== 1 || last_type !== 1'b0) begin
      errors++; $display("FAIL rst_recover got unl=%b n=%0d type=%b want 1/1/0", unlocked, pulses - p0, last_type);
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_code();
    test_lockout();
    test_timeout();
    test_invalid_keys();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Central controller of the digital lock.
- Consumes debounced keypad events (4-bit key code plus held-level strobe) and assembles a CODE_LEN-digit entry, then compares it against a stored code.
- Commands the LED blinker through a start/done handshake to show success or failure, then drives the lock state.
- Sits between the keypad scanner and the blinker/LED drivers in the top level.

Parameters:
- CODE_LEN, 4, number of digits per entry (1..7).
- CODE, 16'h1234, expected code, one 4-bit digit per nibble, first digit most significant; only the low 4*CODE_LEN bits are used.
- MAX_FAILS, 3, consecutive wrong entries that trigger lockout (1..7).
- TIMEOUT_CYCLES, 60_000_000, idle cycles allowed between digits before the entry is discarded.
- LOCKOUT_CYCLES, 120_000_000, lockout duration in cycles.

Ports:
- hwclk, in, 1, system clock.
- rst, in, 1, asynchronous reset, active-high.
- button, in, 4, key code from the keypad scanner; valid digits are 1..9 and 0 means no key; stable while bstate is high.
- bstate, in, 1, key-held level from the scanner; asynchronous to this logic.
- start_blinking, out, 1, one-cycle request pulse to the blinker.
- blink_type, out, 1, pattern select: 0 = success, 1 = failure; held stable from the pulse until the handshake completes.
- done_blinking, in, 1, blinker idle/done level.
- unlocked, out, 1, lock open.
- locked_out, out, 1, lockout active.
- digit_count, out, 3, digits entered so far.
- fail_count, out, 3, consecutive failures.

Behaviour:
- Reset values: every output is 0. State is IDLE; entry register, counters and synchronizer flops are cleared. Reset asserted mid-operation aborts immediately, including an in-flight blink; start_blinking is forced to 0.
- Synchronization: bstate passes through a 2-flop synchronizer.
- Press event: a rising edge of the synchronized bstate (0 then 1 on consecutive cycles). button is sampled on the same cycle as the edge. A press with button equal to 0 or greater than 9 is ignored everywhere.
- State IDLE: a valid press loads the digit into the entry register, sets digit_count to 1, and moves to ENTRY.
- State ENTRY:
  - A valid press shifts the digit in (entry <= {entry, digit}), increments digit_count and clears the idle counter.
  - When digit_count reaches CODE_LEN, move to CHECK on the next cycle.
  - The idle counter increments every cycle without a press. When it reaches TIMEOUT_CYCLES-1: discard the entry, set digit_count to 0, go to IDLE. A timeout does not count as a failure.
- State CHECK: lasts exactly one cycle and compares entry to CODE.
  - Match: fail_count is set to 0; start_blinking is pulsed with blink_type=0; next state BLINK_ACK.
  - Mismatch: fail_count is incremented (saturating at 7); start_blinking is pulsed with blink_type=1; next state BLINK_ACK.
  - digit_count is cleared in this cycle.
- State BLINK_ACK: wait for done_blinking=0, meaning the blinker has accepted the request.
- State BLINK_WAIT: wait for done_blinking=1. The following state is:
  - UNLOCKED after a match.
  - LOCKOUT after a mismatch when fail_count equals MAX_FAILS.
  - IDLE otherwise.
- Latency: from the last digit edge, CHECK occurs one cycle later, and start_blinking rises in the CHECK cycle.
- State UNLOCKED: unlocked=1. Any valid press relocks: unlocked goes to 0, the state goes to IDLE, and the press is consumed (not stored as a digit).
- State LOCKOUT: locked_out=1 and all presses are ignored. A counter runs for LOCKOUT_CYCLES; at expiry, fail_count is set to 0, locked_out to 0, and the state returns to IDLE.
- Presses during CHECK, BLINK_ACK or BLINK_WAIT are dropped.
- A press and a timeout on the same cycle: the press wins.
- No combinational path exists from any input to any output.

Decomposition:
- Shared package lock_pkg holds:
  - FSM state encoding: IDLE, ENTRY, CHECK, BLINK_ACK, BLINK_WAIT, UNLOCKED, LOCKOUT.
  - BLINK_OK=0 and BLINK_FAIL=1.
  - KEY_NONE=0, KEY_MIN=1, KEY_MAX=9.
- One natural sub-module: press_detect, containing the 2-flop synchronizer, the rising-edge detector and digit validation. It outputs a one-cycle press_valid and press_digit.

Test Plan (bench uses CODE_LEN=4, CODE=16'h1234, MAX_FAILS=3, TIMEOUT_CYCLES=100, LOCKOUT_CYCLES=200, and a blinker model that drops done 2 cycles after start and raises it 10 cycles later):
- Press 1,2,3,4 -> digit_count steps 1..4; one start_blinking pulse with blink_type=0; unlocked=1 after done rises; fail_count=0. A further press of 5 -> unlocked=0, digit_count=0.
- Press 1,2,3,5 -> start_blinking pulse with blink_type=1; fail_count=1; state back to IDLE; unlocked stays 0.
- Three wrong codes in a row -> fail_count=3 and locked_out=1. Presses during the lockout change nothing. locked_out=0 and fail_count=0 exactly 200 cycles after lockout entry.
- Press 1,2, then idle for 100 cycles -> digit_count=0 and fail_count unchanged. Then 1,2,3,4 -> unlock.
- Button=0 or 11 with bstate toggled, plus bstate held high across many cycles -> no digit stored, and only one digit per rising edge.
- Assert rst during BLINK_WAIT and during ENTRY -> all outputs 0 immediately. The next 1,2,3,4 unlocks normally.
